tm1638_board_ctrl: RTL
======================

// Module: tm1638_board_ctrl
// PURPOSE
//  Downstream/upstream board stage for the hackathon game top: drives a TM1638 LED&KEY board.
//  Captures the multiplexed 7-segment outputs (abcdefgh/digit) and led[7:0] into a frame buffer.
//  Refreshes the TM1638 over its 3-wire serial bus.
//  Scans the 8 board keys and returns them as the key[7:0] input of the game.
// PARAMETERS
//  clk_mhz     27   system clock frequency, MHz
//  tm_clk_khz  500  TM1638 CLK frequency; half period HP = clk_mhz*1000/(2*tm_clk_khz) cycles (27)
//  brightness  7    display-control intensity field, 0..7
//  read_wait   2    idle HP count between the read command and the first read bit (>=1 us)
// PORTS
//  clock       in   1  system clock
//  reset_n     in   1  asynchronous active-low reset
//  led         in   8  LED i on when led[i]=1
//  abcdefgh    in   8  segments of currently selected digit, active-high, bit7=a .. bit0=dp
//  digit       in   8  one-hot active-high digit select, bit i = display position i
//  key         out  8  debounced-by-frame key state, 1 = pressed
//  tm_stb      out  1  TM1638 STB, active-low
//  tm_clk      out  1  TM1638 CLK, idle high
//  tm_dio_out  out  1  DIO value when driving
//  tm_dio_oe   out  1  1 = drive DIO, 0 = release (pad pull-up)
//  tm_dio_in   in   1  DIO pad value, asynchronous
//  frame_done  out  1  one-cycle pulse when a full write+read frame completes
// BEHAVIOUR
//  Reset (async, reset_n=0): tm_stb=1, tm_clk=1, tm_dio_out=1, tm_dio_oe=0, key=0, frame_done=0,
//   seg_buf[0..7]=0, FSM=IDLE, timers cleared. Outputs recover on first clock after release.
//  Capture: every clock, for each i with digit[i]=1, seg_buf[i] <= abcdefgh; digit=0 updates nothing;
//   multiple bits set update all selected entries. led sampled at frame start only.
//  Snapshot: on IDLE->CMD_WR, seg_buf and led are copied to shadow regs; frame sends shadow only.
//  Segment remap: TM byte bit0=a..bit6=g, bit7=dp, i.e. tm_seg = bit-reverse(abcdefgh).
//  Bit timing: all serial activity on an HP tick counter. Each bit = CLK low for 1 HP (DIO updated
//   on the falling edge cycle), then CLK high for 1 HP. Bytes sent/received LSB first.
//  Reads: tm_dio_in passes a 2-flop synchronizer; sampled on last cycle of the CLK-high HP.
//  FSM (STB low during each command group, STB high for 2 HP between groups):
//   IDLE    -> CMD_WR after 2 HP with STB high
//   CMD_WR  : byte 0x40 (write, auto-increment)
//   ADDR_WR : byte 0xC0, then 16 bytes; addr 2i = tm_seg[i], addr 2i+1 = {7'b0, led[i]}
//   DISP    : byte 0x88 | brightness
//   CMD_RD  : byte 0x42; then tm_dio_oe=0, CLK high, wait read_wait HP
//   RD      : 32 CLK pulses reading bytes B0..B3, tm_dio_oe stays 0
//   DONE    : STB high, key[i]=Bi[0], key[i+4]=Bi[4] (i=0..3), all 8 bits updated in one cycle;
//             frame_done=1 that cycle; -> IDLE
//  tm_dio_oe=1 from STB fall of any write group until STB rise; DIO driven 1 when STB high.
//  key only changes in DONE; never shows partial read data.
//  Frame = 24 bytes = 384 HP + gaps. Continuous refresh, no external trigger.
//  Counters free of wrap hazards: HP counter ceil(log2(HP)) bits, bit/byte counters saturate at end.
// TESTING
//  1 reset_n=0 mid ADDR_WR -> same cycle tm_stb=1, tm_clk=1, tm_dio_oe=0; key held 0;
//    after release, 2 HP later STB falls and 0x40 restarts.
//  2 Bus monitor decodes first frame after reset -> groups {0x40}, {0xC0 + 16 bytes}, {0x8F}, {0x42};
//    tm_clk half period = 27 cycles.
//  3 digit=8'h04, abcdefgh=8'h80 for 1 cycle, then digit=0 -> next frame addr 0x04 byte=0x01;
//    led=8'h81 -> addr 0x01=0x01, addr 0x0F=0x01, others 0.
//  4 TM model returns B0..B3 = 0x01,0x00,0x10,0x00 -> at frame_done key=8'h41; unchanged before DONE.
//  5 abcdefgh changes while ADDR_WR is in progress -> current frame sends snapshot;
//    new value appears next frame.
//  6 DIO contention check: model drives DIO only while tm_dio_oe=0 -> no overlap for 3 full frames.

Source files
------------

// File: rtl/tm1638_board_ctrl.sv
// tm1638_board_ctrl: refreshes a TM1638 LED&KEY board from the muxed
// 7-seg/led game outputs and scans its 8 keys back once per frame.
module tm1638_board_ctrl #(
    parameter int clk_mhz    = 27,
    parameter int tm_clk_khz = 500,
    parameter int brightness = 7,
    parameter int read_wait  = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] led,
    input  logic [7:0] abcdefgh,
    input  logic [7:0] digit,
    output logic [7:0] key,
    output logic       tm_stb,
    output logic       tm_clk,
    output logic       tm_dio_out,
    output logic       tm_dio_oe,
    input  logic       tm_dio_in,
    output logic       frame_done
);

    localparam int HP  = clk_mhz * 1000 / (2 * tm_clk_khz);
    localparam int HPW = (HP > 1) ? $clog2(HP) : 1;
    localparam logic [HPW-1:0] HP_LAST = HPW'(HP - 1);
    localparam logic [3:0]     RW_LAST = 4'(read_wait - 1);
    localparam logic [2:0]     BRIGHT  = 3'(brightness);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD_WR,
        S_G_ADDR,
        S_ADDR_WR,
        S_G_DISP,
        S_DISP,
        S_G_RD,
        S_CMD_RD,
        S_RD_WAIT,
        S_RD,
        S_DONE
    } state_e;

    state_e state;
    state_e state_nx;

    logic [HPW-1:0] hp_cnt;
    logic           tick;
    logic [3:0]     hb;
    logic [4:0]     byte_idx;
    logic           byte_end;

    logic [7:0] seg_buf [8];
    logic [7:0] shd_seg [8];
    logic [7:0] shd_led;

    logic       dio_s1;
    logic       dio_s2;
    logic [7:0] rx_key;

    logic [3:0] slot;
    logic [7:0] wr_data;
    logic [7:0] tx_byte;

    logic stb_d;
    logic clk_d;
    logic dio_d;
    logic oe_d;

    // TM byte order is a..g then dp from bit0, the reverse of abcdefgh
    function automatic logic [7:0] seg_remap(input logic [7:0] s);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = s[7-i];
        end
        return r;
    endfunction

    assign tick     = (hp_cnt == HP_LAST);
    assign byte_end = tick && (hb == 4'd15);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hp_cnt <= '0;
        end else if (state == S_DONE || tick) begin
            hp_cnt <= '0;
        end else begin
            hp_cnt <= hp_cnt + 1'b1;
        end
    end

    // hb counts half periods within a state; byte_idx counts whole bytes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hb       <= '0;
            byte_idx <= '0;
        end else if (state_nx != state) begin
            hb       <= '0;
            byte_idx <= '0;
        end else if (tick) begin
            hb <= hb + 1'b1;
            if (hb == 4'd15 && byte_idx != 5'd16) begin
                byte_idx <= byte_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (tick && hb == 4'd1) state_nx = S_CMD_WR;
            S_CMD_WR:  if (byte_end) state_nx = S_G_ADDR;
            S_G_ADDR:  if (tick && hb == 4'd1) state_nx = S_ADDR_WR;
            S_ADDR_WR: if (byte_end && byte_idx == 5'd16) state_nx = S_G_DISP;
            S_G_DISP:  if (tick && hb == 4'd1) state_nx = S_DISP;
            S_DISP:    if (byte_end) state_nx = S_G_RD;
            S_G_RD:    if (tick && hb == 4'd1) state_nx = S_CMD_RD;
            S_CMD_RD:  if (byte_end) state_nx = S_RD_WAIT;
            S_RD_WAIT: if (tick && hb == RW_LAST) state_nx = S_RD;
            S_RD:      if (byte_end && byte_idx == 5'd3) state_nx = S_DONE;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                seg_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (digit[i]) seg_buf[i] <= abcdefgh;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                shd_seg[i] <= '0;
            end
            shd_led <= '0;
        end else if (state == S_IDLE && state_nx == S_CMD_WR) begin
            shd_seg <= seg_buf;
            shd_led <= led;
        end
    end

    // data bytes follow 0xC0: even slot = segments, odd slot = led
    always_comb begin
        slot = 4'(byte_idx - 5'd1);
        if (slot[0]) begin
            wr_data = {7'b0, shd_led[slot[3:1]]};
        end else begin
            wr_data = seg_remap(shd_seg[slot[3:1]]);
        end
    end

    always_comb begin
        tx_byte = 8'hFF;
        unique case (state)
            S_CMD_WR:  tx_byte = 8'h40;
            S_ADDR_WR: tx_byte = (byte_idx == 5'd0) ? 8'hC0 : wr_data;
            S_DISP:    tx_byte = {5'b10001, BRIGHT};
            S_CMD_RD:  tx_byte = 8'h42;
            default:   tx_byte = 8'hFF;
        endcase
    end

    always_comb begin
        stb_d = 1'b1;
        clk_d = 1'b1;
        dio_d = 1'b1;
        oe_d  = 1'b0;
        unique case (state)
            S_CMD_WR, S_ADDR_WR, S_DISP, S_CMD_RD: begin
                stb_d = 1'b0;
                clk_d = hb[0];
                dio_d = tx_byte[hb[3:1]];
                oe_d  = 1'b1;
            end
            S_RD_WAIT: stb_d = 1'b0;
            S_RD: begin
                stb_d = 1'b0;
                clk_d = hb[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tm_stb     <= 1'b1;
            tm_clk     <= 1'b1;
            tm_dio_out <= 1'b1;
            tm_dio_oe  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tm_stb     <= stb_d;
            tm_clk     <= clk_d;
            tm_dio_out <= dio_d;
            tm_dio_oe  <= oe_d;
            frame_done <= (state == S_DONE);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dio_s1 <= 1'b1;
            dio_s2 <= 1'b1;
        end else begin
            dio_s1 <= tm_dio_in;
            dio_s2 <= dio_s1;
        end
    end

    // only bits 0 and 4 of each read byte carry keys on this board
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_key <= '0;
        end else if (state == S_RD && tick && hb[0] && hb[2:1] == 2'b00) begin
            rx_key[{hb[3], byte_idx[1:0]}] <= dio_s2;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            key <= '0;
        end else if (state == S_DONE) begin
            key <= rx_key;
        end
    end

endmodule
